rob_ctrl: RTL and testbench

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/rob_ctrl.sv | 114 +++++++++++
 tb/tb_rob_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: in-order allocation and retirement with two completion ports.
// An exception at the head flushes the whole buffer through a one-cycle FLUSH state.
module rob_ctrl #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             cmp0_valid,
    input  logic [IDX_W-1:0] cmp0_idx,
    input  logic             cmp0_exc,
    input  logic             cmp1_valid,
    input  logic [IDX_W-1:0] cmp1_idx,
    input  logic             cmp1_exc,
    output logic             commit_valid,
    output logic [IDX_W-1:0] commit_idx,
    input  logic             commit_ready,
    output logic             flush,
    output logic [IDX_W-1:0] flush_idx,
    output logic [IDX_W:0]   count
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] done_q, done_d;
    logic [ENTRIES-1:0] exc_q, exc_d;
    logic [IDX_W:0]     head_q, head_d;
    logic [IDX_W:0]     tail_q, tail_d;

    logic [IDX_W-1:0] head_lo, tail_lo;
    logic             full, in_run, head_ok, commit_ok, flush_hit, grant, retire;

    assign head_lo = head_q[IDX_W-1:0];
    assign tail_lo = tail_q[IDX_W-1:0];
    assign full    = (head_lo == tail_lo) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign in_run  = (state_q == RUN);

    assign head_ok   = busy_q[head_lo] & done_q[head_lo];
    assign commit_ok = in_run & head_ok & ~exc_q[head_lo];
    assign flush_hit = in_run & head_ok & exc_q[head_lo];

    // Outputs are gated by rst so the reset values hold during the reset cycle itself.
    assign alloc_ready  = ~rst & in_run & ~full;
    assign commit_valid = ~rst & commit_ok;
    assign flush        = ~rst & flush_hit;
    assign flush_idx    = flush ? head_lo : '0;
    assign alloc_idx    = rst ? '0 : tail_lo;
    assign commit_idx   = rst ? '0 : head_lo;
    assign count        = rst ? '0 : (tail_q - head_q);

    assign grant  = alloc_req & alloc_ready & ~flush_hit;
    assign retire = commit_valid & commit_ready;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        exc_d   = exc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (!in_run || flush_hit) begin
            // Clearing on entry to FLUSH as well keeps stale completions from leaking through.
            busy_d  = '0;
            done_d  = '0;
            exc_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            state_d = flush_hit ? FLUSH : RUN;
        end else begin
            if (cmp0_valid && busy_q[cmp0_idx]) begin
                done_d[cmp0_idx] = 1'b1;
                exc_d[cmp0_idx]  = exc_d[cmp0_idx] | cmp0_exc;
            end
            if (cmp1_valid && busy_q[cmp1_idx]) begin
                done_d[cmp1_idx] = 1'b1;
                exc_d[cmp1_idx]  = exc_d[cmp1_idx] | cmp1_exc;
            end
            if (grant) begin
                busy_d[tail_lo] = 1'b1;
                done_d[tail_lo] = 1'b0;
                exc_d[tail_lo]  = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            if (retire) begin
                busy_d[head_lo] = 1'b0;
                head_d          = head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            busy_q  <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed vector bench for rob_ctrl: a table of per-cycle inputs and expected outputs,
// followed by hand-written fill/wrap sequences.
module tb_rob_ctrl;

    logic       clk = 1'b0;
    logic       rst, alloc_req, alloc_ready;
    logic [3:0] alloc_idx;
    logic       cmp0_valid, cmp0_exc, cmp1_valid, cmp1_exc;
    logic [3:0] cmp0_idx, cmp1_idx;
    logic       commit_valid, commit_ready, flush;
    logic [3:0] commit_idx, flush_idx;
    logic [4:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst, req, c0v;
        logic [3:0] c0i;
        logic       c0e, c1v;
        logic [3:0] c1i;
        logic       c1e, cr;
        logic       ar;
        logic [3:0] ai;
        logic       cv;
        logic [3:0] ci;
        logic       fl;
        logic [3:0] fi;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl[$];

    rob_ctrl #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmp0_valid(cmp0_valid), .cmp0_idx(cmp0_idx), .cmp0_exc(cmp0_exc),
        .cmp1_valid(cmp1_valid), .cmp1_idx(cmp1_idx), .cmp1_exc(cmp1_exc),
        .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_ready(commit_ready),
        .flush(flush), .flush_idx(flush_idx), .count(count)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(int r, int rq, int c0v, int c0i, int c0e, int c1v, int c1i,
                               int c1e, int cr, int ar, int ai, int cv, int ci, int fl,
                               int fi, int cnt);
        vec_t x;
        x.rst = 1'(r);  x.req = 1'(rq); x.c0v = 1'(c0v); x.c0i = 4'(c0i); x.c0e = 1'(c0e);
        x.c1v = 1'(c1v); x.c1i = 4'(c1i); x.c1e = 1'(c1e); x.cr = 1'(cr);
        x.ar = 1'(ar);  x.ai = 4'(ai);  x.cv = 1'(cv);  x.ci = 4'(ci);
        x.fl = 1'(fl);  x.fi = 4'(fi);  x.cnt = 5'(cnt);
        return x;
    endfunction

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
    task automatic step(input string name, input vec_t x);
        logic [19:0] got, exp;
        rst = x.rst; alloc_req = x.req; commit_ready = x.cr;
        cmp0_valid = x.c0v; cmp0_idx = x.c0i; cmp0_exc = x.c0e;
        cmp1_valid = x.c1v; cmp1_idx = x.c1i; cmp1_exc = x.c1e;
        @(negedge clk);
        got = {alloc_ready, alloc_idx, commit_valid, commit_idx, flush, flush_idx, count};
        exp = {x.ar, x.ai, x.cv, x.ci, x.fl, x.fi, x.cnt};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got ar=%b ai=%0d cv=%b ci=%0d fl=%b fi=%0d cnt=%0d, expected ar=%b ai=%0d cv=%b ci=%0d fl=%b fi=%0d cnt=%0d",
                      name, alloc_ready, alloc_idx, commit_valid, commit_idx, flush, flush_idx,
                      count, x.ar, x.ai, x.cv, x.ci, x.fl, x.fi, x.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                r rq c0v c0i e c1v c1i e cr  ar ai cv ci fl fi cnt
        // Reset, then allocate 0-2 and complete out of order 2,0,1.
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 2));
        tbl.push_back(v(0, 0, 1, 2, 0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 0, 3));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 0, 3));
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 1,  1, 3, 1, 0, 0, 0, 3));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 3, 1, 1, 0, 0, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 3, 1, 2, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 3, 0, 3, 0, 0, 0));
        // Mid-operation reset, allocate 0-3, exception on 1, complete 0.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 2));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 3));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, 1,  1, 4, 0, 0, 0, 0, 4));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1,  1, 4, 0, 0, 0, 0, 4));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 4, 1, 0, 0, 0, 4));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 4, 0, 1, 1, 1, 3));
        tbl.push_back(v(0, 1, 1, 2, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 1));
        // Both ports on entry 0, exception only on port 1.
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 0, 1, 1,  1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        // Completion to unallocated index 5, then reset during FLUSH.
        tbl.push_back(v(0, 0, 1, 5, 1, 1, 5, 0, 1,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Fill all 16 entries back to back.
        for (int i = 0; i < 16; i++)
            step($sformatf("fill%0d", i), v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, i));
        step("full", v(0, 0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 16));
        // Full: retire only; then retire+grant with tail wrapping; then grant back to full.
        step("full_retire", v(0, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 16));
        step("wrap_both",   v(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 0, 15));
        step("wrap_grant",  v(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2, 0, 0, 15));
        step("refull",      v(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 2, 0, 0, 16));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
